// File: rtl/output_row_drain_pkg.sv
// Shared types and helpers for the output row drain: array geometry, the drain
// FSM state type and the int8 saturation used by the requantizer.
package output_row_drain_pkg;

  localparam int ARR_WIDTH = 16;
  localparam int FXP_N     = 16;
  localparam int OUT_W     = 8;

  localparam logic signed [FXP_N:0] SAT_HI = (FXP_N+1)'(127);
  localparam logic signed [FXP_N:0] SAT_LO = (FXP_N+1)'(-128);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } drain_state_t;

  // Clamp a widened, already-shifted value into the signed int8 range.
  function automatic logic signed [OUT_W-1:0] sat8(input logic signed [FXP_N:0] v);
    if (v > SAT_HI) begin
      return 8'sh7F;
    end else if (v < SAT_LO) begin
      return 8'sh80;
    end else begin
      return OUT_W'(v);
    end
  endfunction

endpackage

// File: rtl/output_row_drain_if.sv
// Row stream in from the accelerator and requantized row stream out to the host.
interface output_row_drain_if
  import output_row_drain_pkg::*;
#(
  parameter int ROWS = 128
);

  localparam int IDX_W = $clog2(ROWS);

  logic                         in_valid;
  logic [ARR_WIDTH*FXP_N-1:0]   vec_in;
  logic                         out_ready;
  logic                         out_valid;
  logic [ARR_WIDTH*OUT_W-1:0]   out_data;
  logic [IDX_W-1:0]             out_row_idx;
  logic                         out_last;

  // The drain block itself.
  modport slave (
    input  in_valid, vec_in, out_ready,
    output out_valid, out_data, out_row_idx, out_last
  );

  // The accelerator/host side driving the drain.
  modport master (
    output in_valid, vec_in, out_ready,
    input  out_valid, out_data, out_row_idx, out_last
  );

endinterface

// File: rtl/output_row_drain_sync_row_fifo.sv
// Synchronous FIFO of whole rows: head read combinationally, wrap-bit pointers,
// simultaneous push and pop in the same cycle.
module sync_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: only the pointers are reset; stale storage is unreachable while empty,
  // so the memory array stays a plain register file without a reset network.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_row_drain.sv
// Captures accelerator output rows, requantizes each element to int8 and hands
// them to the host through a small row FIFO tagged with row index and last flag.
module output_row_drain
  import output_row_drain_pkg::*;
#(
  parameter int FRAC_BITS = 6,
  parameter int ROWS      = 128,
  parameter int DEPTH     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output_row_drain_if.slave   bus,
  output logic                frame_done,
  output logic                overflow,
  output logic                busy
);

  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic signed [FXP_N:0] RND_K = (FXP_N+1)'(1 << (FRAC_BITS-1));

  typedef struct packed {
    logic [ARR_WIDTH*OUT_W-1:0] data;
    logic [IDX_W-1:0]           idx;
    logic                       last;
  } entry_t;

  drain_state_t               state;
  logic [IDX_W-1:0]           row_cnt;
  logic [ARR_WIDTH*OUT_W-1:0] q_row;
  entry_t                     wr_entry;
  entry_t                     head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic                       row_in;
  logic                       last_in;
  logic                       push;
  logic                       pop;

  // Round-half-up then arithmetic shift, one extra bit so the rounding add
  // cannot wrap at the top of the input range.
  for (genvar i = 0; i < ARR_WIDTH; i++) begin : g_quant
    logic signed [FXP_N-1:0] x;
    logic signed [FXP_N:0]   xe;
    logic signed [FXP_N:0]   sum;
    logic signed [FXP_N:0]   shifted;

    assign x       = bus.vec_in[i*FXP_N +: FXP_N];
    assign xe      = {x[FXP_N-1], x};
    assign sum     = xe + RND_K;
    assign shifted = sum >>> FRAC_BITS;
    assign q_row[i*OUT_W +: OUT_W] = sat8(shifted);
  end

  assign row_in  = enable & bus.in_valid;
  assign last_in = (row_cnt == IDX_W'(ROWS - 1));

  assign bus.out_valid = enable & ~fifo_empty;
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = row_in & (~fifo_full | pop);

  assign wr_entry.data = q_row;
  assign wr_entry.idx  = row_cnt;
  assign wr_entry.last = last_in;

  sync_row_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head fields are masked while nothing is valid so the host never sees stale rows.
  assign bus.out_data    = bus.out_valid ? head.data : '0;
  assign bus.out_row_idx = bus.out_valid ? head.idx  : '0;
  assign bus.out_last    = bus.out_valid ? head.last : 1'b0;

  assign frame_done = pop & head.last;
  assign busy       = (state != IDLE) | ~fifo_empty;

  // Dropped rows still advance the counter so surviving rows keep their index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else if (row_in) begin
      row_cnt <= last_in ? '0 : row_cnt + 1'b1;
      if (fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state <= last_in ? DRAIN : ACTIVE;
          end
        end
        ACTIVE: begin
          if (bus.in_valid && last_in) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.in_valid) begin
            state <= last_in ? DRAIN : ACTIVE;
          end else if (fifo_empty || (pop && fifo_count == CNT_W'(1))) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_row_drain.sv
// Directed bench for output_row_drain: quantizer corners, a full frame,
// overflow under backpressure, full-plus-pop, enable freeze and mid-frame reset.
module tb_output_row_drain;
  import output_row_drain_pkg::*;

  localparam int ROWS = 128;

  logic clk;
  logic rst_n;
  logic enable;
  logic frame_done;
  logic overflow;
  logic busy;

  int n_cmp;
  int n_err;

  output_row_drain_if #(.ROWS(ROWS)) bus ();

  output_row_drain #(
    .FRAC_BITS (6),
    .ROWS      (ROWS),
    .DEPTH     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantizer written with plain integer division.
  function automatic logic [7:0] q_model(input logic [15:0] raw);
    int x, t, q;
    x = int'($signed(raw));
    t = x + 32;
    q = (t >= 0) ? t / 64 : -((-t + 63) / 64);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  function automatic logic [255:0] gen_row(input int r);
    logic [255:0] v;
    for (int e = 0; e < 16; e++) begin
      v[e*16 +: 16] = 16'(r * 1237 + e * 4099 + 7);
    end
    return v;
  endfunction

  function automatic logic [127:0] exp_row(input logic [255:0] v);
    logic [127:0] o;
    for (int e = 0; e < 16; e++) begin
      o[e*8 +: 8] = q_model(v[e*16 +: 16]);
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [255:0] qv;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    bus.in_valid = 1'b0;
    bus.vec_in = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    #12;
    rst_n = 1'b1;
    tick();

    // 1: quantizer corners in elements 0..4
    qv = '0;
    qv[15:0]  = 16'h0060;
    qv[31:16] = 16'h005F;
    qv[47:32] = 16'h7FFF;
    qv[63:48] = 16'h8000;
    qv[79:64] = 16'hFFE0;
    bus.in_valid = 1'b1;
    bus.vec_in = qv;
    tick();
    bus.in_valid = 1'b0;
    check("q_valid", bus.out_valid, 1);
    check("q_idx", bus.out_row_idx, 0);
    check("q_data", bus.out_data, 128'h807F_0102);
    check("q_busy", busy, 1);
    pulse_reset();

    // 2: full frame back-to-back with host always ready
    bus.out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++) begin
      bus.in_valid = 1'b1;
      bus.vec_in = gen_row(r);
      #1;
      check("ff_valid", bus.out_valid, (r > 0) ? 1 : 0);
      if (r > 0) begin
        check("ff_idx", bus.out_row_idx, r - 1);
        check("ff_data", bus.out_data, exp_row(gen_row(r - 1)));
        check("ff_last", bus.out_last, 0);
        check("ff_done", frame_done, 0);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    check("ff_idx127", bus.out_row_idx, 127);
    check("ff_last127", bus.out_last, 1);
    check("ff_done127", frame_done, 1);
    check("ff_data127", bus.out_data, exp_row(gen_row(127)));
    tick();
    check("ff_empty", bus.out_valid, 0);
    check("ff_busy", busy, 0);
    check("ff_overflow", overflow, 0);

    // 3: backpressure, 12 rows into an 8-deep FIFO
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.in_valid = 1'b1;
      bus.vec_in = gen_row(k);
      #1;
      check("bp_overflow", overflow, (k > 8) ? 1 : 0);
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_overflow_set", overflow, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("bp_idx", bus.out_row_idx, k);
      check("bp_data", bus.out_data, exp_row(gen_row(k)));
      tick();
    end
    check("bp_drained", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.vec_in = gen_row(12);
    tick();
    bus.in_valid = 1'b0;
    check("bp_row12_valid", bus.out_valid, 1);
    check("bp_row12_idx", bus.out_row_idx, 12);
    check("bp_row12_data", bus.out_data, exp_row(gen_row(12)));
    tick();
    check("bp_overflow_sticky", overflow, 1);
    bus.out_ready = 1'b0;
    pulse_reset();
    check("rst_clears_overflow", overflow, 0);

    // 4: full FIFO with simultaneous push and pop
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.vec_in = gen_row(k);
      tick();
    end
    bus.vec_in = gen_row(8);
    bus.out_ready = 1'b1;
    #1;
    check("fp_head_idx", bus.out_row_idx, 0);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("fp_overflow", overflow, 0);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("fp_idx", bus.out_row_idx, k);
      check("fp_data", bus.out_data, exp_row(gen_row(k)));
      tick();
    end
    check("fp_count8", bus.out_valid, 0);

    // 5: enable low for 3 cycles with rows still arriving
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.vec_in = gen_row(9);
    tick();
    enable = 1'b0;
    bus.out_ready = 1'b1;
    bus.vec_in = gen_row(99);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("en_valid", bus.out_valid, 0);
      check("en_done", frame_done, 0);
      tick();
    end
    enable = 1'b1;
    bus.vec_in = gen_row(10);
    #1;
    check("en_head_idx", bus.out_row_idx, 9);
    tick();
    bus.in_valid = 1'b0;
    check("en_next_idx", bus.out_row_idx, 10);
    check("en_next_data", bus.out_data, exp_row(gen_row(10)));
    tick();
    check("en_empty", bus.out_valid, 0);

    // 6: async reset with row 50 at the head
    for (int r = 11; r <= 50; r++) begin
      bus.in_valid = 1'b1;
      bus.vec_in = gen_row(r);
      tick();
    end
    bus.in_valid = 1'b0;
    check("r6_idx50", bus.out_row_idx, 50);
    rst_n = 1'b0;
    #1;
    check("r6_valid", bus.out_valid, 0);
    check("r6_data", bus.out_data, 0);
    check("r6_idx", bus.out_row_idx, 0);
    check("r6_last", bus.out_last, 0);
    check("r6_done", frame_done, 0);
    check("r6_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.vec_in = gen_row(200);
    tick();
    bus.in_valid = 1'b0;
    check("r6_new_valid", bus.out_valid, 1);
    check("r6_new_idx", bus.out_row_idx, 0);
    check("r6_new_data", bus.out_data, exp_row(gen_row(200)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
